// File: rtl/pdm_dac_mc.sv
// Multi-channel PDM DAC: valid/ready frame input into a shadow register, frame-strobed
// transfer to the active register, and one 1st/2nd-order delta-sigma modulator per channel.
module pdm_dac_mc #(
    parameter int CHANNELS    = 2,
    parameter int INPUT_WIDTH = 16,
    parameter int INT_GUARD   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ce,
    input  logic                            frame,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [CHANNELS*INPUT_WIDTH-1:0] s_data,
    input  logic                            order2,
    input  logic                            mute,
    input  logic                            clip_clr,
    output logic [CHANNELS-1:0]             dac_out,
    output logic [CHANNELS-1:0]             clip,
    output logic                            underrun
);
    localparam int W  = INPUT_WIDTH;
    localparam int IW = INPUT_WIDTH + INT_GUARD;
    localparam int SW = IW + 2;   // wide enough that unclamped sums never wrap

    localparam logic signed [SW-1:0] FB_POS  = SW'(2 ** (W - 1));
    localparam logic signed [SW-1:0] FB_NEG  = -FB_POS;
    localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (IW - 2) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [IW-1:0] I_MAX   = SAT_MAX[IW-1:0];
    localparam logic signed [IW-1:0] I_MIN   = ~I_MAX;

    logic [CHANNELS*W-1:0] shadow;
    logic [CHANNELS*W-1:0] active;
    logic                  shadow_full;
    logic                  order_q;
    logic                  order_chg;
    logic                  underrun_set;

    assign s_ready      = !shadow_full;
    assign order_chg    = order_q != order2;
    assign underrun_set = frame && !shadow_full;

    // accept and transfer are mutually exclusive: one needs the shadow empty, the other full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow      <= '0;
            active      <= '0;
            shadow_full <= 1'b0;
            order_q     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            order_q <= order2;
            if (s_valid && s_ready) begin
                shadow      <= s_data;
                shadow_full <= 1'b1;
            end else if (frame && shadow_full) begin
                active      <= shadow;
                shadow_full <= 1'b0;
            end
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (clip_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic signed [IW-1:0] i1_q;
        logic signed [IW-1:0] i2_q;
        logic                 dac_q;
        logic                 clip_q;
        logic [W-1:0]         x_raw;
        logic signed [SW-1:0] x_ext;
        logic signed [SW-1:0] fb;
        logic signed [SW-1:0] sum1;
        logic signed [SW-1:0] sum2;
        logic signed [IW-1:0] i1n;
        logic signed [IW-1:0] i2n;
        logic                 clamp1;
        logic                 clamp2;
        logic                 dac_n;
        logic                 clip_set;

        assign x_raw = active[k*W +: W];

        always_comb begin
            x_ext  = mute ? '0 : {{(SW-W){x_raw[W-1]}}, x_raw};
            fb     = dac_q ? FB_POS : FB_NEG;
            sum1   = {{(SW-IW){i1_q[IW-1]}}, i1_q} + x_ext - fb;
            clamp1 = 1'b0;
            i1n    = sum1[IW-1:0];
            if (sum1 > SAT_MAX) begin
                i1n    = I_MAX;
                clamp1 = 1'b1;
            end else if (sum1 < SAT_MIN) begin
                i1n    = I_MIN;
                clamp1 = 1'b1;
            end
            sum2   = {{(SW-IW){i2_q[IW-1]}}, i2_q} + {{(SW-IW){i1n[IW-1]}}, i1n} - fb;
            clamp2 = 1'b0;
            i2n    = sum2[IW-1:0];
            if (sum2 > SAT_MAX) begin
                i2n    = I_MAX;
                clamp2 = 1'b1;
            end else if (sum2 < SAT_MIN) begin
                i2n    = I_MIN;
                clamp2 = 1'b1;
            end
            dac_n    = order_q ? !i2n[IW-1] : !i1n[IW-1];
            clip_set = ce && !order_chg && (clamp1 || (order_q && clamp2));
        end

        // an order change restarts the loop from zero whether or not ce is high
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                i1_q   <= '0;
                i2_q   <= '0;
                dac_q  <= 1'b0;
                clip_q <= 1'b0;
            end else begin
                if (order_chg) begin
                    i1_q  <= '0;
                    i2_q  <= '0;
                    dac_q <= 1'b0;
                end else if (ce) begin
                    i1_q  <= i1n;
                    i2_q  <= order_q ? i2n : '0;
                    dac_q <= dac_n;
                end
                if (clip_set) begin
                    clip_q <= 1'b1;
                end else if (clip_clr) begin
                    clip_q <= 1'b0;
                end
            end
        end

        assign dac_out[k] = dac_q;
        assign clip[k]    = clip_q;
    end
endmodule

// File: tb/tb_pdm_dac_mc.sv
// Scoreboard bench for pdm_dac_mc (W=8, two channels): stimulus queues expected ranges,
// a negedge monitor measures ones counts / status outputs and compares on each probe.
module tb_pdm_dac_mc;
    localparam int W  = 8;
    localparam int CH = 2;

    localparam int K_ONES0 = 0;
    localparam int K_ONES1 = 1;
    localparam int K_DAC   = 2;
    localparam int K_CLIP  = 3;
    localparam int K_CLIP0 = 4;
    localparam int K_UND   = 5;
    localparam int K_RDY   = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ce = 1'b0;
    logic            frame = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [CH*W-1:0] s_data = '0;
    logic            order2 = 1'b0;
    logic            mute = 1'b0;
    logic            clip_clr = 1'b0;
    logic [CH-1:0]   dac_out;
    logic [CH-1:0]   clip;
    logic            underrun;

    typedef struct {
        string name;
        int    kind;
        int    lo;
        int    hi;
    } exp_t;

    exp_t exp_q[$];
    logic probe = 1'b0;
    logic win_clr = 1'b0;
    logic ce_at_edge = 1'b0;
    int   ones0 = 0;
    int   ones1 = 0;
    int   checks = 0;
    int   errors = 0;

    pdm_dac_mc #(.CHANNELS(CH), .INPUT_WIDTH(W), .INT_GUARD(4)) dut (
        .clk(clk), .rst(rst), .ce(ce), .frame(frame), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .order2(order2), .mute(mute),
        .clip_clr(clip_clr), .dac_out(dac_out), .clip(clip), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ce_at_edge <= ce;

    function automatic int observe(input int kind);
        case (kind)
            K_ONES0: return ones0;
            K_ONES1: return ones1;
            K_DAC:   return int'(dac_out);
            K_CLIP:  return int'(clip);
            K_CLIP0: return int'(clip[0]);
            K_UND:   return int'(underrun);
            default: return int'(s_ready);
        endcase
    endfunction

    always @(negedge clk) begin
        if (win_clr) begin
            ones0 <= 0;
            ones1 <= 0;
        end else if (ce_at_edge) begin
            ones0 <= ones0 + int'(dac_out[0]);
            ones1 <= ones1 + int'(dac_out[1]);
        end
        if (probe) begin
            checks <= checks + 1;
            if (exp_q.size() == 0) begin
                errors <= errors + 1;
                $display("FAIL scoreboard_empty: probe with no expected entry at %0t", $time);
            end else begin
                if (observe(exp_q[0].kind) < exp_q[0].lo || observe(exp_q[0].kind) > exp_q[0].hi) begin
                    errors <= errors + 1;
                    $display("FAIL %s: got %0d, expected %0d..%0d", exp_q[0].name,
                             observe(exp_q[0].kind), exp_q[0].lo, exp_q[0].hi);
                end
                exp_q.delete(0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string name, input int kind, input int lo, input int hi);
        exp_q.push_back('{name, kind, lo, hi});
    endtask

    task automatic expect_v(input string name, input int kind, input int lo, input int hi);
        push(name, kind, lo, hi);
        probe = 1'b1;
        tick(1);
        probe = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!s_ready && n < 50) begin
            tick(1);
            n++;
        end
        expect_v("ready_before_load", K_RDY, 1, 1);
        s_valid = 1'b1;
        s_data  = {b, a};
        tick(1);
        s_valid = 1'b0;
        s_data  = '0;
        frame   = 1'b1;
        tick(1);
        frame   = 1'b0;
    endtask

    // two order toggles restart both modulators from zero, leaving the order as it was
    task automatic clear_loop();
        order2 = !order2;
        tick(1);
        order2 = !order2;
        tick(1);
    endtask

    task automatic run_win(input int n);
        win_clr = 1'b1;
        ce      = 1'b1;
        tick(1);
        win_clr = 1'b0;
        tick(n - 1);
        ce = 1'b0;
        tick(1);
    endtask

    task automatic frame_pulse();
        frame = 1'b1;
        tick(1);
        frame = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        #2 rst = 1'b1;
        tick(1);
        expect_v("reset_ready", K_RDY, 1, 1);
        expect_v("reset_dac", K_DAC, 0, 0);
        expect_v("reset_clip", K_CLIP, 0, 0);
        expect_v("reset_underrun", K_UND, 0, 0);

        // zero input, 1st order: 1,1,0,1,0,1,0,1 on both channels
        push("seq0_pre", K_DAC, 0, 0);
        push("seq0_t1", K_DAC, 3, 3);
        push("seq0_t2", K_DAC, 3, 3);
        push("seq0_t3", K_DAC, 0, 0);
        push("seq0_t4", K_DAC, 3, 3);
        push("seq0_t5", K_DAC, 0, 0);
        push("seq0_t6", K_DAC, 3, 3);
        push("seq0_t7", K_DAC, 0, 0);
        push("seq0_t8", K_DAC, 3, 3);
        ce    = 1'b1;
        probe = 1'b1;
        tick(9);
        probe = 1'b0;
        ce    = 1'b0;
        expect_v("seq0_no_clip", K_CLIP, 0, 0);

        // 1st order full-scale positive: 511 ones in 512 ticks
        load(8'h7F, 8'h00);
        clear_loop();
        run_win(512);
        expect_v("o1_pos_full_ones", K_ONES0, 509, 511);
        expect_v("o1_zero_ones_ch1", K_ONES1, 256, 258);
        expect_v("o1_pos_full_no_clip", K_CLIP, 0, 0);

        // 1st order full-scale negative: a single leading one
        load(8'h80, 8'h00);
        clear_loop();
        run_win(64);
        expect_v("o1_neg_full_ones", K_ONES0, 1, 1);

        // 2nd order, x=+64: density 0.75
        order2 = 1'b1;
        tick(1);
        load(8'h40, 8'h00);
        clear_loop();
        run_win(1024);
        expect_v("o2_half_ones", K_ONES0, 758, 778);

        // 2nd order near full scale overloads the second integrator
        load(8'h7F, 8'h00);
        clear_loop();
        run_win(4096);
        expect_v("o2_full_clip", K_CLIP0, 1, 1);
        clip_clr = 1'b1;
        tick(1);
        clip_clr = 1'b0;
        expect_v("clip_cleared", K_CLIP, 0, 0);

        // handshake: held s_valid accepts once, later data ignored
        order2 = 1'b0;
        tick(1);
        clear_loop();
        s_valid = 1'b1;
        s_data  = {8'hE0, 8'h20};
        tick(1);
        s_data = '0;
        tick(3);
        expect_v("ready_low_while_full", K_RDY, 0, 0);
        s_valid = 1'b0;
        frame_pulse();
        expect_v("ready_after_frame", K_RDY, 1, 1);
        clear_loop();
        run_win(256);
        expect_v("o1_p32_ones_ch0", K_ONES0, 158, 162);
        expect_v("o1_m32_ones_ch1", K_ONES1, 94, 98);

        // frame with nothing pending: underrun, active unchanged
        frame_pulse();
        expect_v("underrun_on_empty_frame", K_UND, 1, 1);
        clear_loop();
        run_win(256);
        expect_v("active_held_after_underrun", K_ONES0, 158, 162);

        mute = 1'b1;
        clear_loop();
        run_win(256);
        expect_v("mute_ones_ch0", K_ONES0, 127, 129);
        expect_v("mute_ones_ch1", K_ONES1, 127, 129);
        mute = 1'b0;

        // accept and frame together with shadow empty
        clip_clr = 1'b1;
        tick(1);
        clip_clr = 1'b0;
        expect_v("underrun_cleared", K_UND, 0, 0);
        s_valid = 1'b1;
        s_data  = {8'h40, 8'hC0};
        frame   = 1'b1;
        tick(1);
        s_valid = 1'b0;
        frame   = 1'b0;
        expect_v("underrun_on_same_cycle", K_UND, 1, 1);
        expect_v("shadow_filled_same_cycle", K_RDY, 0, 0);
        frame_pulse();
        expect_v("ready_after_second_frame", K_RDY, 1, 1);
        clear_loop();
        run_win(256);
        expect_v("o1_m64_ones_ch0", K_ONES0, 62, 66);
        expect_v("o1_p64_ones_ch1", K_ONES1, 190, 194);

        frame    = 1'b1;
        clip_clr = 1'b1;
        tick(1);
        frame    = 1'b0;
        clip_clr = 1'b0;
        expect_v("underrun_set_wins", K_UND, 1, 1);

        // order change clears loop state with and without ce
        clear_loop();
        ce = 1'b1;
        tick(1);
        ce = 1'b0;
        expect_v("first_tick_ones", K_DAC, 3, 3);
        order2 = 1'b1;
        tick(1);
        expect_v("order_change_clears_ce0", K_DAC, 0, 0);
        ce = 1'b1;
        tick(1);
        ce = 1'b0;
        expect_v("o2_first_tick_ones", K_DAC, 3, 3);
        order2 = 1'b0;
        ce     = 1'b1;
        tick(1);
        ce = 1'b0;
        expect_v("order_change_clears_ce1", K_DAC, 0, 0);
        mute = 1'b1;
        push("restart_pre", K_DAC, 0, 0);
        push("restart_t1", K_DAC, 3, 3);
        push("restart_t2", K_DAC, 3, 3);
        push("restart_t3", K_DAC, 0, 0);
        push("restart_t4", K_DAC, 3, 3);
        ce    = 1'b1;
        probe = 1'b1;
        tick(5);
        probe = 1'b0;
        ce    = 1'b0;
        mute  = 1'b0;

        // asynchronous reset mid-stream
        frame_pulse();
        s_valid = 1'b1;
        s_data  = {8'h10, 8'h10};
        tick(1);
        s_valid = 1'b0;
        expect_v("pre_reset_ready_low", K_RDY, 0, 0);
        ce = 1'b1;
        tick(5);
        #2 rst = 1'b0;
        expect_v("mid_reset_ready", K_RDY, 1, 1);
        expect_v("mid_reset_dac", K_DAC, 0, 0);
        expect_v("mid_reset_underrun", K_UND, 0, 0);
        expect_v("mid_reset_clip", K_CLIP, 0, 0);
        ce  = 1'b0;
        rst = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
